// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard I/O controller.
// Contents: pop FSM state encoding, bus register word indices, PS/2 prefix bytes,
// DATA/STATUS bit positions, the key-event struct and a DATA word packing helper.
package kbd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StGap
  } state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // DATA word layout
  localparam int unsigned DATA_VALID_BIT = 31;
  localparam int unsigned DATA_EXT_BIT   = 9;
  localparam int unsigned DATA_BRK_BIT   = 8;

  // STATUS word layout
  localparam int unsigned ST_VALID_BIT   = 0;
  localparam int unsigned ST_READY_BIT   = 1;
  localparam int unsigned ST_FULL_BIT    = 2;
  localparam int unsigned ST_OVERRUN_BIT = 3;
  localparam int unsigned ST_IRQ_EN_BIT  = 4;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  function automatic logic [31:0] pack_data(input logic valid, input key_evt_t e);
    logic [31:0] d;
    d                 = '0;
    d[DATA_VALID_BIT] = valid;
    d[DATA_EXT_BIT]   = e.ext;
    d[DATA_BRK_BIT]   = e.brk;
    d[7:0]            = e.code;
    return d;
  endfunction

endpackage

// File: rtl/kbd_scan_decode.sv
// Folds E0/F0 prefix bytes into one key event and holds that event for the CPU.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   pop_i, pop_byte_i - a byte is being popped this cycle, and its value
//   evt_clr_i         - CPU read of DATA; drops evt_valid at this edge
//   evt_valid_o       - an unread event is held
//   evt_valid_next_o  - value evt_valid takes at the next edge
//   evt_o             - held event {ext, brk, code}
// A pending prefix is discarded after PREFIX_TIMEOUT cycles with no further pop.
module kbd_scan_decode
  import kbd_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pop_i,
  input  logic [7:0] pop_byte_i,
  input  logic       evt_clr_i,
  output logic       evt_valid_o,
  output logic       evt_valid_next_o,
  output key_evt_t   evt_o
);

  localparam int unsigned TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(PREFIX_TIMEOUT - 1);

  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          evt_valid_q, evt_valid_d;
  key_evt_t      evt_q, evt_d;

  always_comb begin
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    tmo_d       = tmo_q;
    evt_valid_d = evt_valid_q;
    evt_d       = evt_q;

    if (evt_clr_i) begin
      evt_valid_d = 1'b0;
    end

    if (pop_i) begin
      tmo_d = '0;
      if (pop_byte_i == SC_EXT) begin
        ext_pend_d = 1'b1;
      end else if (pop_byte_i == SC_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        // A new event overrides a coincident clear so it is never lost.
        evt_d.ext   = ext_pend_q;
        evt_d.brk   = brk_pend_q;
        evt_d.code  = pop_byte_i;
        evt_valid_d = 1'b1;
        ext_pend_d  = 1'b0;
        brk_pend_d  = 1'b0;
      end
    end else if (ext_pend_q || brk_pend_q) begin
      if (tmo_q == TmoLast) begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        tmo_d      = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      tmo_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_q       <= '0;
    end else begin
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      tmo_q       <= tmo_d;
      evt_valid_q <= evt_valid_d;
      evt_q       <= evt_d;
    end
  end

  assign evt_valid_o      = evt_valid_q;
  assign evt_valid_next_o = evt_valid_d;
  assign evt_o            = evt_q;

endmodule

// File: rtl/kbd_io_ctrl.sv
// Memory-mapped controller between the CPU bus and keyboard_buffer.
// Pops raw PS/2 bytes with one-cycle kb_read pulses, folds prefixes into key events via
// kbd_scan_decode, and exposes DATA/STATUS/CTRL registers.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   kb_ready, kb_full, kb_key - keyboard_buffer status and head byte
//   kb_read                   - one-cycle pop pulse to keyboard_buffer
//   cs, we, addr, wdata       - bus access (addr is a word index)
//   rdata                     - combinational read data, 0 when cs is low
//   irq                       - level interrupt request
// Build option: define KBD_IRQ_EN to implement CTRL.irq_en and irq; otherwise irq is tied 0
// and CTRL reads 0.
module kbd_io_ctrl
  import kbd_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned PREFIX_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kb_ready,
  input  logic        kb_full,
  input  logic [7:0]  kb_key,
  output logic        kb_read,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

  state_e     state_q;
  logic [3:0] gap_q;
  logic       kb_read_q;
  logic       overrun_q;
  logic       evt_valid;
  logic       evt_valid_next;
  key_evt_t   evt;
  logic       irq_en;

  logic bus_rd, bus_wr, data_rd;
  assign bus_rd  = cs && !we;
  assign bus_wr  = cs && we;
  assign data_rd = bus_rd && (addr == ADDR_DATA);

  // Pop FSM; kb_read is high exactly while in StPop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gap_q     <= '0;
      kb_read_q <= 1'b0;
    end else begin
      kb_read_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // Backpressure: an occupied event register blocks the pop, even if it is
          // being read this very cycle.
          if (kb_ready && !evt_valid) begin
            state_q   <= StPop;
            kb_read_q <= 1'b1;
          end
        end
        StPop: begin
          state_q <= StGap;
          gap_q   <= '0;
        end
        StGap: begin
          if (gap_q == GapLast) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign kb_read = kb_read_q;

  kbd_scan_decode #(
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
  ) u_scan_decode (
    .clk             (clk),
    .rst             (rst),
    .pop_i           (kb_read_q),
    .pop_byte_i      (kb_key),
    .evt_clr_i       (data_rd),
    .evt_valid_o     (evt_valid),
    .evt_valid_next_o(evt_valid_next),
    .evt_o           (evt)
  );

  // Sticky overrun; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (kb_full && evt_valid) begin
      overrun_q <= 1'b1;
    end else if (bus_wr && (addr == ADDR_STATUS) && wdata[ST_OVERRUN_BIT]) begin
      overrun_q <= 1'b0;
    end
  end

`ifdef KBD_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;
  logic unused_wdata;

  assign irq_en_d = (bus_wr && (addr == ADDR_CTRL)) ? wdata[0] : irq_en_q;

  // Registered from next-state values so irq tracks irq_en & evt_valid without lag and
  // drops on the same edge as the DATA read.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_d && evt_valid_next;
    end
  end

  assign irq_en       = irq_en_q;
  assign irq          = irq_q;
  assign unused_wdata = ^{wdata[31:4], wdata[2:1]};
`else
  logic unused_wdata;

  assign irq_en       = 1'b0;
  assign irq          = 1'b0;
  assign unused_wdata = ^{wdata[31:4], wdata[2:0], evt_valid_next};
`endif

  always_comb begin
    rdata = '0;
    if (cs) begin
      case (addr)
        ADDR_DATA: rdata = pack_data(evt_valid, evt);
        ADDR_STATUS: begin
          rdata[ST_VALID_BIT]   = evt_valid;
          rdata[ST_READY_BIT]   = kb_ready;
          rdata[ST_FULL_BIT]    = kb_full;
          rdata[ST_OVERRUN_BIT] = overrun_q;
          rdata[ST_IRQ_EN_BIT]  = irq_en;
        end
        ADDR_CTRL: rdata[0] = irq_en;
        default:   rdata = '0;
      endcase
    end
  end

endmodule
